// File: rtl/round_sequencer.sv
// round_sequencer: round/lives/level sequencer for the arithmetic-target game.
// Optional pause support (pauseKey/paused ports) is compiled in with `define ROUND_SEQ_PAUSE_EN.
module round_sequencer #(
    parameter int ROUND_FRAMES  = 1800,
    parameter int RESULT_FRAMES = 120,
    parameter int LIVES         = 3,
    parameter int SCORE_W       = 10
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      startKey,
    input  logic                      playerDeath,
    input  logic signed [SCORE_W-1:0] score,
    input  logic        [7:0]         goal,
`ifdef ROUND_SEQ_PAUSE_EN
    input  logic                      pauseKey,
    output logic                      paused,
`endif
    output logic                      newGoal,
    output logic                      clearScore,
    output logic                      roundActive,
    output logic        [10:0]        framesLeft,
    output logic        [1:0]         lives,
    output logic        [3:0]         level,
    output logic                      winPulse,
    output logic                      gameOver
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NEWGOAL = 3'd1,
        S_SETTLE  = 3'd2,
        S_PLAY    = 3'd3,
        S_WIN     = 3'd4,
        S_LOSE    = 3'd5,
        S_OVER    = 3'd6
    } state_t;

    localparam logic [10:0] ROUND_C  = 11'(ROUND_FRAMES);
    localparam logic [10:0] RESULT_C = 11'(RESULT_FRAMES);
    localparam logic [1:0]  LIVES_C  = 2'(LIVES);

    state_t             r_state, w_next;
    logic               r_start_d;
    logic [10:0]        r_frames_left, w_frames_nx;
    logic [10:0]        r_hold_cnt, w_hold_nx;
    logic [1:0]         r_lives, w_lives_nx;
    logic [3:0]         r_level, w_level_nx;
    logic               r_new_goal, r_clear_score, r_round_active, r_win_pulse, r_game_over;
    logic               w_start_ev, w_pause_ev, w_paused, w_paused_nx, w_win, w_lose;
    logic [SCORE_W:0]   w_score_ext, w_goal_ext;

    assign w_start_ev  = startKey & ~r_start_d;
    assign w_score_ext = {score[SCORE_W-1], score};
    assign w_goal_ext  = {{(SCORE_W-7){1'b0}}, goal};
    assign w_win       = (w_score_ext == w_goal_ext);
    assign w_lose      = playerDeath | (r_frames_left == 11'd0);

`ifdef ROUND_SEQ_PAUSE_EN
    logic r_pause_d, r_paused;
    assign w_pause_ev = pauseKey & ~r_pause_d;
    assign w_paused   = r_paused;
    assign paused     = r_paused;

    // Pause key edge register and pause flag
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pause_d <= 1'b0;
            r_paused  <= 1'b0;
        end else begin
            r_pause_d <= pauseKey;
            r_paused  <= w_paused_nx;
        end
    end
`else
    assign w_pause_ev = 1'b0;
    assign w_paused   = 1'b0;
`endif

    // Next state plus next counter/lives/level values; a transition always pre-empts counting
    always_comb begin
        w_next      = r_state;
        w_frames_nx = r_frames_left;
        w_hold_nx   = r_hold_cnt;
        w_lives_nx  = r_lives;
        w_level_nx  = r_level;
        w_paused_nx = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_ev) begin
                    w_next     = S_NEWGOAL;
                    w_lives_nx = LIVES_C;
                    w_level_nx = 4'd0;
                end else begin
                    w_next = r_state;
                end
            end
            S_NEWGOAL: begin
                w_frames_nx = ROUND_C;
                w_next      = S_SETTLE;
            end
            S_SETTLE: begin
                w_next = S_PLAY;
            end
            S_PLAY: begin
                if (w_paused) begin
                    w_paused_nx = ~w_pause_ev;
                end else if (w_win) begin
                    w_next     = S_WIN;
                    w_hold_nx  = RESULT_C;
                    w_level_nx = (r_level == 4'd15) ? r_level : r_level + 4'd1;
                end else if (w_lose) begin
                    w_next     = S_LOSE;
                    w_lives_nx = r_lives - 2'd1;
                    w_hold_nx  = (r_lives == 2'd1) ? r_hold_cnt : RESULT_C;
                end else begin
                    w_paused_nx = w_pause_ev;
                    w_frames_nx = (startOfFrame && (r_frames_left != 11'd0)) ?
                                  r_frames_left - 11'd1 : r_frames_left;
                end
            end
            S_WIN, S_LOSE: begin
                // Losing the last life skips the result hold entirely
                if ((r_state == S_LOSE) && (r_lives == 2'd0)) begin
                    w_next = S_OVER;
                end else if (r_hold_cnt == 11'd0) begin
                    w_next = S_NEWGOAL;
                end else if (startOfFrame) begin
                    w_hold_nx = r_hold_cnt - 11'd1;
                end else begin
                    w_hold_nx = r_hold_cnt;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, counters and Moore outputs, all registered from next-state values
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state        <= S_IDLE;
            r_start_d      <= 1'b0;
            r_frames_left  <= ROUND_C;
            r_hold_cnt     <= 11'd0;
            r_lives        <= LIVES_C;
            r_level        <= 4'd0;
            r_new_goal     <= 1'b0;
            r_clear_score  <= 1'b0;
            r_round_active <= 1'b0;
            r_win_pulse    <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_start_d      <= startKey;
            r_frames_left  <= w_frames_nx;
            r_hold_cnt     <= w_hold_nx;
            r_lives        <= w_lives_nx;
            r_level        <= w_level_nx;
            r_new_goal     <= (w_next == S_NEWGOAL);
            r_clear_score  <= (w_next == S_NEWGOAL);
            r_round_active <= (w_next == S_PLAY) & ~w_paused_nx;
            r_win_pulse    <= (r_state == S_PLAY) && (w_next == S_WIN);
            r_game_over    <= (w_next == S_OVER);
        end
    end

    assign newGoal     = r_new_goal;
    assign clearScore  = r_clear_score;
    assign roundActive = r_round_active;
    assign framesLeft  = r_frames_left;
    assign lives       = r_lives;
    assign level       = r_level;
    assign winPulse    = r_win_pulse;
    assign gameOver    = r_game_over;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: directed game flow with randomized goals,
// scores and frame spacing, checked against a game-level expectation model.
module tb_round_sequencer;
    localparam int RF = 1800;
    localparam int HF = 120;
    localparam int NL = 3;
    localparam int SW = 10;

    logic                 clk = 1'b0;
    logic                 resetN, startOfFrame, startKey, playerDeath;
    logic signed [SW-1:0] score;
    logic [7:0]           goal;
    logic                 newGoal, clearScore, roundActive, winPulse, gameOver;
    logic [10:0]          framesLeft;
    logic [1:0]           lives;
    logic [3:0]           level;
`ifdef ROUND_SEQ_PAUSE_EN
    logic                 pauseKey, paused;
`endif

    int   n_cmp = 0;
    int   n_fail = 0;
    int   ng_cnt = 0;
    int   cs_cnt = 0;
    int   ng_exp = 0;
    int   exp_lives, exp_level, exp_frames;
    logic bad_frames = 1'b0;

    always #5 clk = ~clk;

    round_sequencer #(.ROUND_FRAMES(RF), .RESULT_FRAMES(HF), .LIVES(NL), .SCORE_W(SW)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey),
        .playerDeath(playerDeath), .score(score), .goal(goal),
`ifdef ROUND_SEQ_PAUSE_EN
        .pauseKey(pauseKey), .paused(paused),
`endif
        .newGoal(newGoal), .clearScore(clearScore), .roundActive(roundActive),
        .framesLeft(framesLeft), .lives(lives), .level(level),
        .winPulse(winPulse), .gameOver(gameOver)
    );

    // Pulse counters and out-of-range frame watch
    always @(negedge clk) begin
        if (newGoal === 1'b1) ng_cnt <= ng_cnt + 1;
        if (clearScore === 1'b1) cs_cnt <= cs_cnt + 1;
        if (resetN === 1'b1 && framesLeft > 11'd1800) bad_frames <= 1'b1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [SW-1:0] pick_miss(input logic [7:0] g);
        logic [SW-1:0] s;
        do s = SW'($urandom_range(0, 1023)); while (s == {2'b00, g});
        return s;
    endfunction

    task automatic frames(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(0, maxgap));
            startOfFrame = 1'b1;
            tick(1);
            startOfFrame = 1'b0;
        end
    endtask

    task automatic wait_play(input string tag);
        int k = 0;
        while (roundActive !== 1'b1 && k < 10) begin
            tick(1);
            k++;
        end
        check({tag, "_active"}, roundActive, 1);
        check({tag, "_frames"}, framesLeft, RF);
        check({tag, "_lives"}, lives, exp_lives);
        check({tag, "_level"}, level, exp_level);
        check({tag, "_newgoals"}, ng_cnt, ng_exp);
        check({tag, "_clears"}, cs_cnt, ng_exp);
        exp_frames = RF;
    endtask

    task automatic hold_out(input string tag, input int maxgap);
        frames(HF - 1, maxgap);
        tick(3);
        check({tag, "_early"}, ng_cnt, ng_exp);
        goal  = 8'($urandom_range(1, 150));
        score = pick_miss(goal);
        frames(1, 0);
        ng_exp++;
        wait_play(tag);
    endtask

    task automatic restart(input string tag);
        startKey = 1'b1;
        tick(1);
        startKey = 1'b0;
        check({tag, "_pulse"}, newGoal, 1);
        check({tag, "_over"}, gameOver, 0);
        ng_exp++;
        exp_lives = NL;
        exp_level = 0;
        goal  = 8'($urandom_range(1, 150));
        score = pick_miss(goal);
        wait_play(tag);
    endtask

    task automatic die(input string tag);
        int k = $urandom_range(0, 10);
        frames(k, 1);
        exp_frames = exp_frames - k;
        playerDeath = 1'b1;
        tick(1);
        playerDeath = 1'b0;
        exp_lives--;
        check({tag, "_lives"}, lives, exp_lives);
        if (exp_lives == 0) begin
            tick(1);
            check({tag, "_gameover"}, gameOver, 1);
            check({tag, "_lives0"}, lives, 0);
            frames(20, 1);
            playerDeath = 1'b1;
            tick(1);
            playerDeath = 1'b0;
            check({tag, "_frozen"}, framesLeft, exp_frames);
            check({tag, "_overlives"}, lives, 0);
        end else begin
            playerDeath = 1'b1;
            tick(1);
            playerDeath = 1'b0;
            check({tag, "_ignored"}, lives, exp_lives);
            hold_out(tag, 1);
        end
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b0; playerDeath = 1'b0;
        goal = 8'd42; score = -10'sd42;
`ifdef ROUND_SEQ_PAUSE_EN
        pauseKey = 1'b0;
`endif
        tick(3);
        check("rst_newgoal", newGoal, 0);
        check("rst_clear", clearScore, 0);
        check("rst_active", roundActive, 0);
        check("rst_win", winPulse, 0);
        check("rst_over", gameOver, 0);
        check("rst_frames", framesLeft, RF);
        check("rst_lives", lives, NL);
        check("rst_level", level, 0);
        resetN = 1'b1;
        tick(2);
        check("idle_quiet", ng_cnt, 0);

        // First start: exact pulse timing
        startKey = 1'b1;
        tick(1);
        check("start_newgoal", newGoal, 1);
        check("start_clear", clearScore, 1);
        tick(1);
        check("settle_newgoal", newGoal, 0);
        check("settle_clear", clearScore, 0);
        check("settle_active", roundActive, 0);
        tick(1);
        startKey = 1'b0;
        ng_exp = 1; exp_lives = NL; exp_level = 0;
        wait_play("play1");

        // Near-miss scores that share low bits with the goal must not win
        score = 10'sd298;
        tick(2);
        score = -10'sd470;
        tick(2);
        check("alias_nowin", level, 0);
        check("alias_active", roundActive, 1);
        score = -10'sd42;

        // Start edge during PLAY is ignored
        startKey = 1'b1;
        tick(2);
        startKey = 1'b0;
        tick(1);
        check("play_start_ign", ng_cnt, ng_exp);

        // Partial countdown then a win
        begin
            int k = $urandom_range(5, 40);
            frames(k, 2);
            exp_frames = RF - k;
            check("count_partial", framesLeft, exp_frames);
        end
        score = 10'sd42;
        tick(1);
        exp_level = 1;
        check("win_pulse", winPulse, 1);
        check("win_level", level, exp_level);
        check("win_inactive", roundActive, 0);
        score = -10'sd42;
        tick(1);
        check("win_pulse_off", winPulse, 0);
        hold_out("win_hold", 2);

        // Full timeout
        frames(RF / 2, 1);
        check("timeout_half", framesLeft, RF / 2);
        frames(RF / 2, 1);
        check("timeout_zero", framesLeft, 0);
        tick(1);
        exp_lives--;
        check("timeout_lives", lives, exp_lives);
        check("timeout_nowrap", framesLeft, 0);
        check("timeout_inactive", roundActive, 0);
        hold_out("lose_hold", 1);

        // Spend remaining lives, restart, then three deaths from a fresh game
        while (exp_lives > 0) die("death_a");
        restart("restart_a");
        for (int i = 0; i < NL; i++) die("death_b");
        restart("restart_b");

        // Win and death together: win has priority
        score = {2'b00, goal};
        playerDeath = 1'b1;
        tick(1);
        playerDeath = 1'b0;
        score = pick_miss(goal);
        exp_level = 1;
        check("prio_win", winPulse, 1);
        check("prio_lives", lives, exp_lives);
        check("prio_level", level, exp_level);
        hold_out("prio_hold", 0);

        // Level saturates at 15
        for (int i = 0; i < 16; i++) begin
            score = {2'b00, goal};
            tick(1);
            score = pick_miss(goal);
            exp_level = (exp_level < 15) ? exp_level + 1 : 15;
            check("sat_level", level, exp_level);
            hold_out("sat_hold", 0);
        end

`ifdef ROUND_SEQ_PAUSE_EN
        frames(RF - 1000, 0);
        pauseKey = 1'b1;
        tick(1);
        pauseKey = 1'b0;
        check("pause_on", paused, 1);
        check("pause_inactive", roundActive, 0);
        frames(50, 1);
        score = {2'b00, goal};
        playerDeath = 1'b1;
        tick(1);
        playerDeath = 1'b0;
        score = pick_miss(goal);
        check("pause_frames", framesLeft, 1000);
        check("pause_lives", lives, exp_lives);
        check("pause_level", level, exp_level);
        pauseKey = 1'b1;
        tick(1);
        pauseKey = 1'b0;
        tick(1);
        check("pause_off", paused, 0);
        frames(10, 1);
        check("unpause_frames", framesLeft, 990);
`endif

        // Asynchronous reset mid-round
        frames(7, 1);
        resetN = 1'b0;
        #1;
        check("mid_rst_active", roundActive, 0);
        check("mid_rst_frames", framesLeft, RF);
        check("mid_rst_lives", lives, NL);
        check("mid_rst_level", level, 0);
        check("mid_rst_over", gameOver, 0);
        check("mid_rst_win", winPulse, 0);
        tick(2);
        resetN = 1'b1;
        tick(5);
        check("post_rst_quiet", ng_cnt, ng_exp);
        check("post_rst_idle", roundActive, 0);
        check("frames_in_range", bad_frames, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-level sequencer for the arithmetic-target game. Starts and ends rounds, requests a new goal and a score clear from the score datapath, and runs the per-round frame countdown.
- Compares the running signed score against the current goal and decides win or lose, tracking lives and level.
- Sits between the keypad/collision logic and the score controller. Its outputs drive the VGA status overlay.

Parameters:
- ROUND_FRAMES, 1800, frames per round (30 s at 60 Hz).
- RESULT_FRAMES, 120, frames the WIN/LOSE result is held before the next round.
- LIVES, 3, lives at game start (1..3).
- SCORE_W, 10, width of the signed score input.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- startKey  in  1  level; start/restart request
- playerDeath  in  1  one-cycle pulse, player killed
- score  in  SCORE_W  signed running score
- goal  in  8  unsigned target value (1..150)
- newGoal  out  1  one-cycle pulse, request a new random goal
- clearScore  out  1  one-cycle pulse, zero the score datapath
- roundActive  out  1  high while in PLAY
- framesLeft  out  11  remaining frames in the round
- lives  out  2  remaining lives
- level  out  4  rounds won, saturating at 15
- winPulse  out  1  one-cycle pulse on round win
- gameOver  out  1  high in OVER

Behaviour:
- Clock and reset: single clock domain, clk. resetN is asynchronous, active-low; all flops clear immediately on assertion.
- Reset values: state=IDLE, newGoal=0, clearScore=0, roundActive=0, winPulse=0, gameOver=0, framesLeft=ROUND_FRAMES, lives=LIVES, level=0, holdCnt=0, startKey edge register=0.
- startKey is edge-detected internally. Only its rising edge counts as a start event.
- States: IDLE, NEWGOAL, SETTLE, PLAY, WIN, LOSE, OVER.
- IDLE:
  - start event: lives<=LIVES, level<=0, go NEWGOAL.
- NEWGOAL (exactly 1 cycle):
  - newGoal=1 and clearScore=1 for this cycle only.
  - framesLeft<=ROUND_FRAMES; go SETTLE.
- SETTLE (exactly 1 cycle): lets goal and score update; no comparison; go PLAY.
- PLAY:
  - roundActive=1.
  - On startOfFrame with framesLeft>0: framesLeft decrements. framesLeft never wraps below 0.
  - Win condition: score == $signed({1'b0,goal}), sign-extended to SCORE_W+1. Checked every cycle.
  - Lose condition: playerDeath, or framesLeft==0.
  - Win has priority over lose in the same cycle.
- WIN:
  - Entry cycle: winPulse=1; level<=level+1, saturating at 15; holdCnt<=RESULT_FRAMES.
  - holdCnt decrements on startOfFrame; at holdCnt==0, go NEWGOAL.
- LOSE:
  - Entry cycle: lives<=lives-1.
  - If lives was 1 on entry: go OVER on the next cycle, lives=0.
  - Otherwise: holdCnt<=RESULT_FRAMES, count down as in WIN, then go NEWGOAL.
- OVER:
  - gameOver=1; framesLeft frozen.
  - start event: lives<=LIVES, level<=0, go NEWGOAL.
- Event handling outside PLAY:
  - playerDeath is ignored in every state except PLAY.
  - A start event in PLAY/WIN/LOSE is ignored.
- startOfFrame coincident with a state transition:
  - The transition wins.
  - Counters are loaded, not decremented, on load cycles.
- Reset mid-round: immediate return to reset values. No newGoal or clearScore pulse is issued until the next start event.
- All outputs are registered (Moore). Latency from win detection to winPulse is 1 cycle.

Optional Feature:
- Macro: ROUND_SEQ_PAUSE_EN.
- When defined:
  - Extra input pauseKey (1 bit, level) and output paused (1 bit).
  - A rising edge of pauseKey in PLAY toggles paused.
  - While paused: framesLeft is frozen; win/lose checks are suppressed; playerDeath is ignored; roundActive=0.
  - paused clears on leaving PLAY and on reset. A pauseKey edge outside PLAY is ignored.
- When undefined: no port is added, and behaviour is exactly as above.

Test Plan:
- Reset, then startKey rising edge → newGoal=1 and clearScore=1 for exactly 1 cycle, 1 cycle after the edge. PLAY is reached 2 cycles later with framesLeft=1800, lives=3, level=0.
- In PLAY: goal=42, drive score=42 → winPulse for 1 cycle next cycle, level=1. After 120 startOfFrame pulses, one newGoal pulse.
- goal=42, score=-42 → no win. 1800 startOfFrame pulses → framesLeft reaches 0, LOSE, lives=2, then a new round. framesLeft never shows 2047.
- Three consecutive playerDeath pulses in PLAY (waiting out each result hold) → lives 3→2→1→0 and gameOver=1. A further startKey edge → lives=3, level=0, newGoal pulse.
- Same cycle: score==goal and playerDeath=1 → WIN taken, lives unchanged. Separately: resetN asserted mid-PLAY → all outputs at reset values immediately.
- With ROUND_SEQ_PAUSE_EN: pause at framesLeft=1000, run 50 startOfFrame pulses and a playerDeath → framesLeft=1000, lives unchanged. Unpause, then 10 startOfFrame pulses → framesLeft=990.
